// File: rtl/booth_bus_master.sv
// Purpose: host-side initiator that sequences the serial Booth multiplier bus and returns a 2*WIDTH product.
// Latency: accept at edge N, bus_start at N+1, A at N+2+GAP_CYCLES, B one cycle later, result two cycles after done.
// Backpressure: one transaction in flight; op_ready low until the result is taken via res_valid/res_ready.
// Optional: define BOOTH_MASTER_CHECK_EN to build the signed product self-checker driving res_mismatch.
module booth_bus_master #(
   parameter int WIDTH      = 5,
   parameter int GAP_CYCLES = 1,
   parameter int TIMEOUT    = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [2*WIDTH-1:0]   res_product,
   output logic                 res_timeout,
   output logic                 res_mismatch,
   output logic                 bus_start,
   output logic [WIDTH-1:0]     bus_data,
   input  logic [WIDTH-1:0]     bus_result,
   input  logic                 bus_done
);

   // one counter serves both the gap and the done wait, so size it for the larger bound
   localparam int CMAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_GAP, S_SEND_A, S_SEND_B, S_WAIT_DONE, S_GET_HI, S_RESP
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [CW-1:0]        r_cnt;
   logic [WIDTH-1:0]     r_a;
   logic [WIDTH-1:0]     r_b;
   logic [2*WIDTH-1:0]   r_prod;
   logic                 r_timeout;
   logic                 w_accept;
   logic                 w_gap_last;
   logic                 w_to_last;

   assign w_accept   = op_valid && (r_state == S_IDLE);
   assign w_gap_last = (r_cnt == CW'(GAP_CYCLES - 1));
   assign w_to_last  = (r_cnt == CW'(TIMEOUT - 1));

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state logic; done beats the timeout terminal count
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (op_valid) w_next = S_START;
         S_START:     w_next = (GAP_CYCLES > 0) ? S_GAP : S_SEND_A;
         S_GAP:       if (w_gap_last) w_next = S_SEND_A;
         S_SEND_A:    w_next = S_SEND_B;
         S_SEND_B:    w_next = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (bus_done)       w_next = S_GET_HI;
            else if (w_to_last) w_next = S_RESP;
         end
         S_GET_HI:    w_next = S_RESP;
         S_RESP:      if (res_ready) w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // Moore outputs decoded from state only
   always_comb begin
      op_ready  = (r_state == S_IDLE);
      res_valid = (r_state == S_RESP);
      bus_start = (r_state == S_START);
      bus_data  = '0;
      if (r_state == S_SEND_A) bus_data = r_a;
      if (r_state == S_SEND_B) bus_data = r_b;
   end

   // gap / wait counter: runs only in GAP and WAIT_DONE, zero elsewhere
   always_ff @(posedge clk) begin
      if (rst)                                             r_cnt <= '0;
      else if (r_state == S_GAP || r_state == S_WAIT_DONE) r_cnt <= r_cnt + 1'b1;
      else                                                 r_cnt <= '0;
   end

   // operand latch and product/timeout collection
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a       <= '0;
         r_b       <= '0;
         r_prod    <= '0;
         r_timeout <= 1'b0;
      end else if (w_accept) begin
         r_a       <= op_a;
         r_b       <= op_b;
         r_prod    <= '0;
         r_timeout <= 1'b0;
      end else if (r_state == S_WAIT_DONE) begin
         if (bus_done) begin
            r_prod[WIDTH-1:0] <= bus_result;
         end else if (w_to_last) begin
            r_prod    <= '0;
            r_timeout <= 1'b1;
         end
      end else if (r_state == S_GET_HI) begin
         r_prod[2*WIDTH-1:WIDTH] <= bus_result;
      end
   end

   assign res_product = r_prod;
   assign res_timeout = r_timeout;

`ifdef BOOTH_MASTER_CHECK_EN
   logic [2*WIDTH-1:0]   r_exp;
   logic                 r_mismatch;
   logic [2*WIDTH-1:0]   w_exp_calc;
   logic [2*WIDTH-1:0]   w_a_ext;
   logic [2*WIDTH-1:0]   w_b_ext;

   // sign-extend to full width so the truncated product is the signed result
   assign w_a_ext    = {{WIDTH{op_a[WIDTH-1]}}, op_a};
   assign w_b_ext    = {{WIDTH{op_b[WIDTH-1]}}, op_b};
   assign w_exp_calc = w_a_ext * w_b_ext;

   // expected product at accept, compared once the high word arrives
   always_ff @(posedge clk) begin
      if (rst) begin
         r_exp      <= '0;
         r_mismatch <= 1'b0;
      end else if (w_accept) begin
         r_exp      <= w_exp_calc;
         r_mismatch <= 1'b0;
      end else if (r_state == S_GET_HI) begin
         r_mismatch <= ({bus_result, r_prod[WIDTH-1:0]} != r_exp);
      end
   end

   assign res_mismatch = r_mismatch;
`else
   assign res_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_booth_bus_master.sv
// Purpose: directed, table-driven bench for booth_bus_master with a hand-driven bus responder.
// Latency: drives and samples on the falling edge, half a cycle away from the active edge.
// Backpressure: holds res_ready low in RESP with new operands pending and checks the master stalls.
module tb_booth_bus_master;
   localparam int W   = 5;
   localparam int GAP = 1;
   localparam int TO  = 64;
`ifdef BOOTH_MASTER_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           op_valid = 1'b0;
   logic           op_ready;
   logic [W-1:0]   op_a = '0;
   logic [W-1:0]   op_b = '0;
   logic           res_valid;
   logic           res_ready = 1'b0;
   logic [2*W-1:0] res_product;
   logic           res_timeout;
   logic           res_mismatch;
   logic           bus_start;
   logic [W-1:0]   bus_data;
   logic [W-1:0]   bus_result = '0;
   logic           bus_done = 1'b0;

   int checks   = 0;
   int failures = 0;

   booth_bus_master #(.WIDTH(W), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
      .res_timeout(res_timeout), .res_mismatch(res_mismatch),
      .bus_start(bus_start), .bus_data(bus_data),
      .bus_result(bus_result), .bus_done(bus_done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [W-1:0]   lo;
      logic [W-1:0]   hi;
      int             dly;
      logic [2*W-1:0] prod;
      logic           mm;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // present operands, wait for accept, then check the start / gap / A / B bus sequence
   task automatic send_ops(input logic [W-1:0] a, input logic [W-1:0] b);
      op_a = a;
      op_b = b;
      op_valid = 1'b1;
      for (int i = 0; i < 100 && !op_ready; i++) @(negedge clk);
      chk("accept_ready", op_ready, 1);
      @(negedge clk);
      op_valid = 1'b0;
      chk("start_pulse", bus_start, 1);
      chk("start_ready_low", op_ready, 0);
      chk("start_data_zero", bus_data, 0);
      for (int g = 0; g < GAP; g++) begin
         @(negedge clk);
         chk("gap_start_low", bus_start, 0);
         chk("gap_data_zero", bus_data, 0);
      end
      @(negedge clk);
      chk("send_a", bus_data, a);
      chk("send_a_start_low", bus_start, 0);
      @(negedge clk);
      chk("send_b", bus_data, b);
   endtask

   // responder: done after dly idle WAIT_DONE cycles with low word, then high word
   task automatic respond(input logic [W-1:0] lo, input logic [W-1:0] hi, input int dly);
      @(negedge clk);
      repeat (dly) @(negedge clk);
      bus_done = 1'b1;
      bus_result = lo;
      @(negedge clk);
      bus_done = 1'b0;
      bus_result = hi;
      @(negedge clk);
      bus_result = '0;
   endtask

   task automatic check_resp(input logic [2*W-1:0] prod, input logic to, input logic mm);
      chk("res_valid", res_valid, 1);
      chk("res_product", res_product, prod);
      chk("res_timeout", res_timeout, to);
      chk("res_mismatch", res_mismatch, mm);
   endtask

   task automatic release_resp();
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("post_resp_valid_low", res_valid, 0);
      chk("post_resp_ready", op_ready, 1);
   endtask

   task automatic run_vec(input vec_t v);
      send_ops(v.a, v.b);
      respond(v.lo, v.hi, v.dly);
      check_resp(v.prod, 1'b0, v.mm);
      release_resp();
   endtask

   initial begin
      int wait_cycles;

      //          a         b         lo        hi        dly prod              mm
      vecs[0] = '{5'd3,     5'd5,     5'b01111, 5'b00000, 0,  10'd15,           1'b0};
      vecs[1] = '{5'b11100, 5'd7,     5'b00100, 5'b11111, 2,  10'b1111100100,   1'b0};
      vecs[2] = '{5'b10000, 5'b10000, 5'b00000, 5'b01000, 5,  10'b0100000000,   1'b0};
      // done lands exactly on the last WAIT_DONE cycle: must be captured, no timeout
      vecs[3] = '{5'b01111, 5'b10000, 5'b10000, 5'b11000, 63, 10'b1100010000,   1'b0};
      // responder returns 16 for 3*5
      vecs[4] = '{5'd3,     5'd5,     5'b10000, 5'b00000, 1,  10'd16,           CHK};

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_op_ready", op_ready, 1);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_product", res_product, 0);
      chk("rst_res_timeout", res_timeout, 0);
      chk("rst_res_mismatch", res_mismatch, 0);
      chk("rst_bus_start", bus_start, 0);
      chk("rst_bus_data", bus_data, 0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // timeout: no done ever, count WAIT_DONE cycles until the result shows up
      send_ops(5'd9, 5'd2);
      wait_cycles = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (res_valid) break;
         wait_cycles++;
      end
      chk("timeout_wait_cycles", wait_cycles, TO);
      check_resp('0, 1'b1, 1'b0);
      release_resp();
      run_vec(vecs[0]);

      // backpressure: new operands pending while the result is held
      send_ops(5'd3, 5'd5);
      respond(5'b01111, 5'b00000, 0);
      op_a = 5'd7;
      op_b = 5'd2;
      op_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("bp_valid", res_valid, 1);
         chk("bp_product", res_product, 10'd15);
         chk("bp_op_ready_low", op_ready, 0);
         chk("bp_no_start", bus_start, 0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk("bp_handshake_valid_low", res_valid, 0);
      chk("bp_handshake_ready", op_ready, 1);
      send_ops(5'd7, 5'd2);
      respond(5'b01110, 5'b00000, 1);
      check_resp(10'd14, 1'b0, 1'b0);
      release_resp();

      // reset in the middle of WAIT_DONE, then a late done must be ignored
      send_ops(5'd5, 5'd5);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_op_ready", op_ready, 1);
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_bus_data", bus_data, 0);
      chk("midrst_bus_start", bus_start, 0);
      bus_done = 1'b1;
      bus_result = 5'b11001;
      @(negedge clk);
      bus_done = 1'b0;
      bus_result = '0;
      repeat (3) @(negedge clk);
      chk("late_done_res_valid", res_valid, 0);
      chk("late_done_op_ready", op_ready, 1);
      chk("late_done_bus_start", bus_start, 0);
      run_vec(vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
